pr_rm_sequencer: RTL and testbench
==================================

PR_RM_SEQUENCER -- requirements
Module: pr_rm_sequencer

Interface
REQ-001 Parameter QUIESCE_CYCLES, default 8, cycles decouple is held before ICAP load starts (range 1..255).
REQ-002 Parameter RST_HOLD_CYCLES, default 16, cycles RM reset is held after load completes (range 1..255).
REQ-003 Parameter TIMEOUT_CYCLES, default 1048576, maximum LOAD wait for icap_done (used only with PR_SEQ_TIMEOUT_EN).
REQ-004 Parameter INIT_ID, default 0, 2-bit RM id resident after device configuration.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req_valid  in  1  swap request valid.
REQ-008 req_id  in  2  target RM id.
REQ-009 req_ready  out  1  sequencer can accept a request.
REQ-010 icap_start  out  1  one-cycle load-start pulse to the ICAP/bitstream loader.
REQ-011 icap_id  out  2  RM id to load, stable from icap_start until icap_done.
REQ-012 icap_done  in  1  one-cycle loader completion pulse.
REQ-013 icap_err  in  1  loader error, sampled only with icap_done.
REQ-014 decouple  out  1  isolates the RM outputs from static logic.
REQ-015 rm_rst  out  1  active-high reset to the RM partition.
REQ-016 active_id  out  2  id of the resident RM; active_valid  out  1  resident RM known good.
REQ-017 done  out  1  one-cycle pulse when a request completes successfully.
REQ-018 err  out  1  sticky error flag; err_clr  in  1  clears ERROR state.

Function
REQ-019 States: IDLE, QUIESCE, LOAD, RST_HOLD, RECOUPLE, ERROR; one-hot or binary at implementer's choice.
REQ-020 req_ready = 1 only in IDLE; a request is accepted on a cycle with req_valid & req_ready; req_id is captured into a target register.
REQ-021 Accepted request with req_id == active_id and active_valid = 1: no reconfiguration; done pulses the next cycle; state stays IDLE.
REQ-022 Otherwise IDLE -> QUIESCE next cycle; decouple = 1 from the first QUIESCE cycle.
REQ-023 QUIESCE lasts exactly QUIESCE_CYCLES cycles, then -> LOAD.
REQ-024 icap_start pulses high on the first LOAD cycle only; icap_id = target.
REQ-025 LOAD: icap_done & !icap_err -> RST_HOLD; icap_done & icap_err -> ERROR; icap_done on the icap_start cycle is accepted.
REQ-026 RST_HOLD: rm_rst = 1, decouple = 1, for exactly RST_HOLD_CYCLES cycles, then -> RECOUPLE.
REQ-027 RECOUPLE (one cycle): rm_rst = 0, decouple = 0, active_id <= target, active_valid <= 1, done = 1; -> IDLE.
REQ-028 active_valid <= 0 on entry to LOAD (resident RM is being overwritten).
REQ-029 ERROR: decouple = 1, rm_rst = 1, err = 1; held until err_clr, then -> IDLE with decouple = 0, rm_rst = 1 for one more cycle, active_valid = 0.
REQ-030 req_valid asserted outside IDLE is not accepted and not queued; the requester holds it.
REQ-031 icap_done outside LOAD is ignored.
REQ-032 Counters are 8-bit (timeout counter 32-bit), cleared on every state entry; no wrap occurs within range.

Reset
REQ-033 rst asserted in any state, including mid-LOAD, returns to IDLE on the next edge.
REQ-034 Reset values: decouple 0, rm_rst 1 (deasserts on the first cycle after rst falls), icap_start 0, icap_id 0, done 0, err 0, active_id INIT_ID, active_valid 1, req_ready 0 during rst.

Configuration
REQ-035 Macro PR_SEQ_TIMEOUT_EN defined: LOAD exits to ERROR if TIMEOUT_CYCLES cycles elapse without icap_done; icap_done on the final cycle takes precedence.
REQ-036 Macro undefined: no timeout counter exists; LOAD waits indefinitely.

Verification
REQ-037 Reset then req_id=1 (active 0), icap_done 5 cycles after icap_start -> decouple high 8+5+16+1 cycles, rm_rst high 16 cycles, done pulse, active_id=1.
REQ-038 req_id=0 while active_id=0, active_valid=1 -> done next cycle, icap_start never pulses, decouple stays 0.
REQ-039 icap_done with icap_err=1 -> ERROR, err=1, rm_rst=1, decouple=1; err_clr -> IDLE, active_valid=0; re-request of id 0 then reloads.
REQ-040 rst asserted 3 cycles into LOAD -> IDLE next edge, decouple=0, rm_rst=1 then 0, active_id=INIT_ID.
REQ-041 PR_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=64, no icap_done -> ERROR after exactly 64 LOAD cycles; undefined -> still LOAD after 1000 cycles.
REQ-042 req_valid held through a swap with req_id=2 -> second acceptance only in the IDLE cycle after done.

Source files
------------

// File: rtl/pr_rm_sequencer.sv
// Partial-reconfiguration swap sequencer: decouple, ICAP load, RM reset hold, recouple.
// Optional LOAD watchdog enabled by defining PR_SEQ_TIMEOUT_EN.
module pr_rm_sequencer #(
  parameter int         QUIESCE_CYCLES  = 8,
  parameter int         RST_HOLD_CYCLES = 16,
  parameter int         TIMEOUT_CYCLES  = 1048576,
  parameter logic [1:0] INIT_ID         = 2'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_id,
  output logic       req_ready,
  output logic       icap_start,
  output logic [1:0] icap_id,
  input  logic       icap_done,
  input  logic       icap_err,
  output logic       decouple,
  output logic       rm_rst,
  output logic [1:0] active_id,
  output logic       active_valid,
  output logic       done,
  output logic       err,
  input  logic       err_clr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUIESCE,
    S_LOAD,
    S_RST_HOLD,
    S_RECOUPLE,
    S_ERROR
  } state_t;

  localparam logic [7:0] QUIESCE_LAST  = 8'(QUIESCE_CYCLES - 1);
  localparam logic [7:0] RST_HOLD_LAST = 8'(RST_HOLD_CYCLES - 1);

  state_t     state;
  state_t     next_state;
  logic [7:0] cnt;
  logic [1:0] target;
  logic       accept;
  logic       entering;

`ifdef PR_SEQ_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tcnt;
`else
  // Parameter kept so both builds share one instantiation signature.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign req_ready = (state == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign entering  = (next_state != state);
  assign icap_id   = target;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept && !(active_valid && (req_id == active_id))) begin
          next_state = S_QUIESCE;
        end
      end
      S_QUIESCE: begin
        if (cnt == QUIESCE_LAST) next_state = S_LOAD;
      end
      S_LOAD: begin
        // A completion on the last watchdog cycle still wins over the timeout.
        if (icap_done) begin
          next_state = icap_err ? S_ERROR : S_RST_HOLD;
        end
`ifdef PR_SEQ_TIMEOUT_EN
        else if (tcnt == TIMEOUT_LAST) begin
          next_state = S_ERROR;
        end
`endif
      end
      S_RST_HOLD: begin
        if (cnt == RST_HOLD_LAST) next_state = S_RECOUPLE;
      end
      S_RECOUPLE: next_state = S_IDLE;
      S_ERROR: begin
        if (err_clr) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (entering) begin
      cnt <= 8'd0;
    end else if ((state == S_QUIESCE) || (state == S_RST_HOLD)) begin
      cnt <= cnt + 8'd1;
    end
  end

`ifdef PR_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= 32'd0;
    end else if (entering) begin
      tcnt <= 32'd0;
    end else if (state == S_LOAD) begin
      tcnt <= tcnt + 32'd1;
    end
  end
`endif

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      target       <= 2'd0;
      decouple     <= 1'b0;
      rm_rst       <= 1'b1;
      icap_start   <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      active_id    <= INIT_ID;
      active_valid <= 1'b1;
    end else begin
      if (accept) target <= req_id;
      decouple   <= (next_state == S_QUIESCE) || (next_state == S_LOAD) ||
                    (next_state == S_RST_HOLD) || (next_state == S_ERROR);
      // Leaving ERROR keeps the partition in reset for one extra IDLE cycle.
      rm_rst     <= (next_state == S_RST_HOLD) || (next_state == S_ERROR) ||
                    (state == S_ERROR);
      icap_start <= (next_state == S_LOAD) && (state != S_LOAD);
      done       <= (accept && (next_state == S_IDLE)) || (next_state == S_RECOUPLE);
      err        <= (next_state == S_ERROR);
      if ((next_state == S_LOAD) && (state != S_LOAD)) begin
        active_valid <= 1'b0;
      end
      if (next_state == S_RECOUPLE) begin
        active_id    <= target;
        active_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pr_rm_sequencer.sv
// Bench for pr_rm_sequencer: directed swap table, error/reset/hold/timeout sequences,
// and random swaps checked against a transaction-level model of the swap rules.
module tb_pr_rm_sequencer;

  localparam int Q = 8;
  localparam int H = 16;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_id;
  logic       req_ready;
  logic       icap_start;
  logic [1:0] icap_id;
  logic       icap_done;
  logic       icap_err;
  logic       decouple;
  logic       rm_rst;
  logic [1:0] active_id;
  logic       active_valid;
  logic       done;
  logic       err;
  logic       err_clr;

  int n_tests = 0;
  int n_fail  = 0;

  pr_rm_sequencer #(
    .QUIESCE_CYCLES (Q),
    .RST_HOLD_CYCLES(H),
    .TIMEOUT_CYCLES (64),
    .INIT_ID        (2'd0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_id      (req_id),
    .req_ready   (req_ready),
    .icap_start  (icap_start),
    .icap_id     (icap_id),
    .icap_done   (icap_done),
    .icap_err    (icap_err),
    .decouple    (decouple),
    .rm_rst      (rm_rst),
    .active_id   (active_id),
    .active_valid(active_valid),
    .done        (done),
    .err         (err),
    .err_clr     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [1:0] id;
    int         lat;
    int         done_at;
    int         dec;
    int         rm;
    int         start;
    logic [1:0] act;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one request and follow it until done, err, or the cycle budget runs out.
  // Cycle k is the k-th cycle after the accepting edge.
  task automatic run_req(input logic [1:0] id, input int lat, input bit e, input bit stray,
                         output int done_at, output int err_at, output int n_dec,
                         output int n_rm, output int n_start, output int id_bad);
    int st_at;
    done_at = -1; err_at = -1; n_dec = 0; n_rm = 0; n_start = 0; id_bad = 0; st_at = -1;
    req_id    = id;
    req_valid = 1'b1;
    for (int w = 0; w < 50 && !req_ready; w++) step(1);
    chk("req_ready_before_accept", int'(req_ready), 1);
    for (int k = 1; k <= 200; k++) begin
      step(1);
      req_valid = 1'b0;
      icap_done = 1'b0;
      icap_err  = 1'b0;
      if (decouple) n_dec++;
      if (rm_rst) n_rm++;
      if (icap_start) begin
        n_start++;
        st_at = k;
      end
      if (st_at >= 0 && icap_id != id) id_bad++;
      if (st_at >= 0 && k == st_at + lat) begin
        icap_done = 1'b1;
        icap_err  = e;
      end
      if (stray && k == 2 && st_at < 0) begin
        icap_done = 1'b1;
        icap_err  = 1'($urandom_range(1));
      end
      if (done) begin
        done_at = k;
        break;
      end
      if (err) begin
        err_at = k;
        break;
      end
    end
    icap_done = 1'b0;
    icap_err  = 1'b0;
  endtask

  task automatic err_seq();
    chk("err_state_err", int'(err), 1);
    chk("err_state_rm_rst", int'(rm_rst), 1);
    chk("err_state_decouple", int'(decouple), 1);
    chk("err_state_active_valid", int'(active_valid), 0);
    chk("err_state_ready", int'(req_ready), 0);
    step(3);
    chk("err_sticky", int'(err), 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("err_clr_err", int'(err), 0);
    chk("err_clr_decouple", int'(decouple), 0);
    chk("err_clr_rm_rst_hold", int'(rm_rst), 1);
    chk("err_clr_active_valid", int'(active_valid), 0);
    chk("err_clr_ready", int'(req_ready), 1);
    step(1);
    chk("err_clr_rm_rst_release", int'(rm_rst), 0);
  endtask

  initial begin
    vec_t       tbl [6];
    int         d_at, e_at, nd, nr, ns, ib, s, acc2, done_k, st;
    logic [1:0] m_active, id;
    logic       m_valid;
    int         lat;
    bit         e, hit;

    // Loads from the default parameters: done at Q+lat+H+2, decouple Q+lat+1+H cycles.
    tbl[0] = '{2'd1, 5, 31, 30, 16, 1, 2'd1};
    tbl[1] = '{2'd1, 0,  1,  0,  0, 0, 2'd1};
    tbl[2] = '{2'd3, 2, 28, 27, 16, 1, 2'd3};
    tbl[3] = '{2'd2, 1, 27, 26, 16, 1, 2'd2};
    tbl[4] = '{2'd0, 0, 26, 25, 16, 1, 2'd0};
    tbl[5] = '{2'd0, 3,  1,  0,  0, 0, 2'd0};

    rst = 1'b1; req_valid = 1'b0; req_id = 2'd0; icap_done = 1'b0; icap_err = 1'b0;
    err_clr = 1'b0;
    step(2);
    chk("rst_decouple", int'(decouple), 0);
    chk("rst_rm_rst", int'(rm_rst), 1);
    chk("rst_icap_start", int'(icap_start), 0);
    chk("rst_icap_id", int'(icap_id), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_active_id", int'(active_id), 0);
    chk("rst_active_valid", int'(active_valid), 1);
    chk("rst_ready", int'(req_ready), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", int'(req_ready), 1);
    step(1);
    chk("post_rst_rm_rst", int'(rm_rst), 0);

    for (int i = 0; i < 6; i++) begin
      run_req(tbl[i].id, tbl[i].lat, 1'b0, 1'b0, d_at, e_at, nd, nr, ns, ib);
      chk($sformatf("vec%0d_done_at", i), d_at, tbl[i].done_at);
      chk($sformatf("vec%0d_decouple_cycles", i), nd, tbl[i].dec);
      chk($sformatf("vec%0d_rm_rst_cycles", i), nr, tbl[i].rm);
      chk($sformatf("vec%0d_icap_starts", i), ns, tbl[i].start);
      chk($sformatf("vec%0d_icap_id", i), ib, 0);
      chk($sformatf("vec%0d_active_id", i), int'(active_id), int'(tbl[i].act));
      chk($sformatf("vec%0d_active_valid", i), int'(active_valid), 1);
    end

    // Loader error, clear, then the former resident id must reload.
    run_req(2'd1, 2, 1'b1, 1'b0, d_at, e_at, nd, nr, ns, ib);
    chk("err_at", e_at, Q + 2 + 2);
    chk("err_no_done", d_at, -1);
    err_seq();
    run_req(2'd0, 0, 1'b0, 1'b0, d_at, e_at, nd, nr, ns, ib);
    chk("reload_starts", ns, 1);
    chk("reload_done_at", d_at, Q + H + 2);
    chk("reload_active_valid", int'(active_valid), 1);

    // Request held across a whole swap: next acceptance only in the IDLE cycle after done.
    step(1);
    req_id = 2'd2; req_valid = 1'b1;
    chk("hold_ready0", int'(req_ready), 1);
    acc2 = -1; done_k = -1; st = -1;
    for (int k = 1; k <= 80; k++) begin
      step(1);
      icap_done = 1'b0;
      if (icap_start) st = k;
      if (st >= 0 && k == st + 1) icap_done = 1'b1;
      if (done && done_k < 0) done_k = k;
      if (acc2 >= 0 && k == acc2 + 1) begin
        chk("hold_second_done", int'(done), 1);
        break;
      end
      if (req_ready && acc2 < 0) acc2 = k;
    end
    icap_done = 1'b0; req_valid = 1'b0;
    chk("hold_done_k", done_k, Q + 1 + H + 2);
    chk("hold_second_accept", acc2, Q + 1 + H + 3);
    step(1);

    // Reset three cycles into LOAD.
    req_id = 2'd1; req_valid = 1'b1;
    chk("rstload_ready", int'(req_ready), 1);
    step(1);
    req_valid = 1'b0;
    s = 0;
    while (!icap_start && s < 20) begin step(1); s++; end
    chk("rstload_start_seen", int'(icap_start), 1);
    step(2);
    chk("rstload_decouple_before", int'(decouple), 1);
    rst = 1'b1;
    step(1);
    chk("rstload_decouple", int'(decouple), 0);
    chk("rstload_rm_rst", int'(rm_rst), 1);
    chk("rstload_active_id", int'(active_id), 0);
    chk("rstload_active_valid", int'(active_valid), 1);
    chk("rstload_ready", int'(req_ready), 0);
    rst = 1'b0;
    #1;
    chk("rstload_ready_after", int'(req_ready), 1);
    step(1);
    chk("rstload_rm_rst_release", int'(rm_rst), 0);

    // LOAD with no completion.
    req_id = 2'd3; req_valid = 1'b1;
    step(1);
    req_valid = 1'b0;
    s = 0;
    while (!icap_start && s < 20) begin step(1); s++; end
    chk("tmo_start_seen", int'(icap_start), 1);
`ifdef PR_SEQ_TIMEOUT_EN
    step(63);
    chk("tmo_last_load_err", int'(err), 0);
    step(1);
    chk("tmo_err", int'(err), 1);
    chk("tmo_decouple", int'(decouple), 1);
`else
    step(1000);
    chk("notmo_err", int'(err), 0);
    chk("notmo_decouple", int'(decouple), 1);
    chk("notmo_done", int'(done), 0);
    chk("notmo_ready", int'(req_ready), 0);
`endif
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);

    // Random swaps against the rule-level model.
    m_active = 2'd0;
    m_valid  = 1'b1;
    for (int t = 0; t < 25; t++) begin
      id  = ($urandom_range(2) == 0) ? m_active : 2'($urandom_range(3));
      lat = $urandom_range(6);
      e   = ($urandom_range(5) == 0);
      hit = m_valid && (id == m_active);
      run_req(id, lat, e, 1'($urandom_range(1)), d_at, e_at, nd, nr, ns, ib);
      if (hit) begin
        chk($sformatf("rnd%0d_hit_done_at", t), d_at, 1);
        chk($sformatf("rnd%0d_hit_starts", t), ns, 0);
        chk($sformatf("rnd%0d_hit_decouple", t), nd, 0);
      end else if (!e) begin
        chk($sformatf("rnd%0d_done_at", t), d_at, Q + lat + H + 2);
        chk($sformatf("rnd%0d_decouple_cycles", t), nd, Q + lat + 1 + H);
        chk($sformatf("rnd%0d_rm_rst_cycles", t), nr, H);
        chk($sformatf("rnd%0d_starts", t), ns, 1);
        chk($sformatf("rnd%0d_icap_id", t), ib, 0);
        m_active = id;
        m_valid  = 1'b1;
      end else begin
        chk($sformatf("rnd%0d_err_at", t), e_at, Q + lat + 2);
        err_seq();
        m_valid = 1'b0;
      end
      chk($sformatf("rnd%0d_active_valid", t), int'(active_valid), int'(m_valid));
      if (m_valid) chk($sformatf("rnd%0d_active_id", t), int'(active_id), int'(m_active));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
